io_port_bank: RTL

//   Parametrised memory-mapped I/O port bank for the DRF system. It replaces the fixed 4-bit io_ports

---
 rtl/io_port_bank.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped bank of N_PORTS I/O ports on the data-memory bus.
// Each port has an output latch (DATA_OUT), a per-bit direction register (DIR),
// a synchronised input view (DATA_IN) and a sticky rising-edge capture (EDGE, W1C).
// Optional feature macro: IO_PORT_BANK_IRQ_EN adds IRQ_MASK and the out_irq output.
module io_port_bank #(
    parameter int                N_PORTS     = 4,
    parameter int                PORT_W      = 4,
    parameter int                ADDR_W      = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 10'h3E0,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           in_addr,
    input  logic                        in_write_en,
    input  logic                        in_read_en,
    input  logic [7:0]                  in_data,
    output logic [7:0]                  out_data,
    output logic                        out_data_valid,
    input  logic [N_PORTS*PORT_W-1:0]   in_port,
    output logic [N_PORTS*PORT_W-1:0]   out_port,
    output logic [N_PORTS*PORT_W-1:0]   out_port_oe
`ifdef IO_PORT_BANK_IRQ_EN
    ,
    output logic                        out_irq
`endif
);

    localparam int PINS_W = N_PORTS * PORT_W;
`ifdef IO_PORT_BANK_IRQ_EN
    localparam int N_REGS = 4 * N_PORTS + 1;
`else
    localparam int N_REGS = 4 * N_PORTS;
`endif
    localparam int ARM_MAX = SYNC_STAGES + 1;

    logic [N_PORTS-1:0][PORT_W-1:0]      data_out_q;
    logic [N_PORTS-1:0][PORT_W-1:0]      dir_q;
    logic [N_PORTS-1:0][PORT_W-1:0]      edge_q;
    logic [N_PORTS-1:0][PORT_W-1:0]      din_view;
    logic [N_PORTS-1:0][PORT_W-1:0]      rise;
    logic [N_PORTS-1:0][PORT_W-1:0]      edge_clr;
    logic [SYNC_STAGES-1:0][PINS_W-1:0]  sync_q;
    logic [PINS_W-1:0]                   prev_q;
    logic [2:0]                          arm_cnt;
    logic                                armed;
    logic [ADDR_W-1:0]                   rel;
    logic                                hit;
    logic [N_PORTS-1:0]                  sel_dout;
    logic [N_PORTS-1:0]                  sel_dir;
    logic [N_PORTS-1:0]                  sel_edge;
    logic [7:0]                          rd_val;
    logic [PORT_W-1:0]                   wr_val;
    logic                                unused_in_data;
`ifdef IO_PORT_BANK_IRQ_EN
    logic [N_PORTS-1:0]                  irq_mask_q;
    logic                                sel_mask;
    logic                                irq_any;
`endif

    // Data bits above PORT_W never reach a register; fold them here so they are consumed.
    assign unused_in_data = ^in_data;
    assign wr_val         = in_data[PORT_W-1:0];
    assign din_view       = sync_q[SYNC_STAGES-1];
    assign rise           = din_view & ~prev_q;
    assign armed          = (arm_cnt == 3'(ARM_MAX));
    assign out_port       = data_out_q;
    assign out_port_oe    = dir_q;

    // Address decode, per-register selects, read mux and W1C masks.
    always_comb begin
        rel      = in_addr - BASE_ADDR;
        hit      = (in_addr >= BASE_ADDR) && (rel < ADDR_W'(N_REGS));
        sel_dout = '0;
        sel_dir  = '0;
        sel_edge = '0;
        rd_val   = '0;
        edge_clr = '0;
`ifdef IO_PORT_BANK_IRQ_EN
        sel_mask = 1'b0;
        irq_any  = 1'b0;
`endif
        for (int i = 0; i < N_PORTS; i++) begin
            if (hit && (rel[ADDR_W-1:2] == (ADDR_W-2)'(i))) begin
                case (rel[1:0])
                    2'd0: begin sel_dout[i] = 1'b1; rd_val = 8'(data_out_q[i]); end
                    2'd1: begin sel_dir[i]  = 1'b1; rd_val = 8'(dir_q[i]);      end
                    2'd2: begin                     rd_val = 8'(din_view[i]);   end
                    default: begin sel_edge[i] = 1'b1; rd_val = 8'(edge_q[i]);  end
                endcase
            end
            if (in_write_en && sel_edge[i]) begin
                edge_clr[i] = wr_val;
            end
        end
`ifdef IO_PORT_BANK_IRQ_EN
        if (hit && (rel == ADDR_W'(4 * N_PORTS))) begin
            sel_mask = 1'b1;
            rd_val   = 8'(irq_mask_q);
        end
        for (int i = 0; i < N_PORTS; i++) begin
            irq_any = irq_any | ((|edge_q[i]) & irq_mask_q[i]);
        end
`endif
    end

    // Pin synchroniser, previous-value flop for edge detect, and post-reset arm counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= '0;
            arm_cnt <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
            if (!armed) begin
                arm_cnt <= arm_cnt + 3'd1;
            end
        end
    end

    // Port registers; a capture on the same bit as a W1C wins because it is OR-ed in last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
            dir_q      <= '0;
            edge_q     <= '0;
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (in_write_en && sel_dout[i]) begin
                    data_out_q[i] <= wr_val;
                end
                if (in_write_en && sel_dir[i]) begin
                    dir_q[i] <= wr_val;
                end
                edge_q[i] <= (edge_q[i] & ~edge_clr[i]) | (rise[i] & {PORT_W{armed}});
            end
        end
    end

    // Registered load result: one-cycle valid pulse, data forced to 0 otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data       <= '0;
            out_data_valid <= 1'b0;
        end else begin
            out_data_valid <= in_read_en && hit;
            out_data       <= (in_read_en && hit) ? rd_val : 8'h00;
        end
    end

`ifdef IO_PORT_BANK_IRQ_EN
    // Interrupt mask register and registered interrupt output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_mask_q <= '0;
            out_irq    <= 1'b0;
        end else begin
            if (in_write_en && sel_mask) begin
                irq_mask_q <= in_data[N_PORTS-1:0];
            end
            out_irq <= irq_any;
        end
    end
`endif

endmodule
